fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_unit_sync.sv | 23 ++
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// FSM state encoding and PC increment codes.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        OUT,
        ACK,
        RELS
    } state_t;

    localparam logic [1:0] INC_HOLD = 2'b00;
    localparam logic [1:0] INC_ONE  = 2'b01;
    localparam logic [1:0] INC_TWO  = 2'b10;

    // Two top opcode bits of 2'b11 mark a two-word instruction.
    function automatic logic [1:0] inc_code(
        input logic [1:0] op,
        input logic       hold
    );
        logic [1:0] c;
        if (hold)
            c = INC_HOLD;
        else if (op == 2'b11)
            c = INC_TWO;
        else
            c = INC_ONE;
        return c;
    endfunction

endpackage

// File: rtl/fetch_unit_sync.sv
// Multi-flop synchronizer for the asynchronous pc_ack strobe.
// Depth set by STAGES, cleared by async active-low reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ff <= '0;
        else
            ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit bridging an asynchronous PC (4-phase pc_ack)
// to a synchronous memory and a valid/ready decoder port.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_ack,
    output logic              pc_ack_out,
    output logic [1:0]        pc_inc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              halt
);

    logic   ack_s;
    state_t state;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pc_ack),
        .q     (ack_s)
    );

    // pc_inc is only updated in CAPT, where pc_ack_out is always low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_ack_out  <= 1'b0;
            pc_inc      <= INC_HOLD;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (ack_s) begin
                        mem_addr <= pc_in;
                        mem_rd   <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    instr       <= mem_rdata;
                    instr_valid <= 1'b1;
                    pc_inc      <= inc_code(
                        mem_rdata[DATA_W-1 -: 2], halt);
                    state       <= OUT;
                end
                OUT: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc_ack_out  <= 1'b1;
                        state       <= ACK;
                    end
                end
                ACK: begin
                    if (!ack_s) begin
                        pc_ack_out <= 1'b0;
                        state      <= RELS;
                    end
                end
                RELS: begin
                    pc_ack_out <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus
// reset-mid-handshake and async PC sequence scenarios.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc_in;
    logic       pc_ack;
    logic       pc_ack_out;
    logic [1:0] pc_inc;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       halt;

    logic [7:0] mem [256];

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] data;
        logic       halt;
        int         stall;
        logic [7:0] exp_instr;
        logic [1:0] exp_inc;
    } vec_t;

    vec_t vecs[6];

    logic [15:0] seen_q[$];
    logic        seq_done;
    logic        seq_tmo;
    logic        prev_v;
    logic [7:0]  seq_pc;
    int          mt;
    int          n;

    fetch_unit #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .pc_ack      (pc_ack),
        .pc_ack_out  (pc_ack_out),
        .pc_inc      (pc_inc),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd)
            mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int         cnt;
        int         rd_cnt;
        logic [7:0] rd_addr;
        logic       bad;
        mem[v.pc] = v.data;
        @(negedge clk);
        pc_in       = v.pc;
        halt        = v.halt;
        instr_ready = (v.stall == 0);
        pc_ack      = 1'b1;
        cnt = 0;
        rd_cnt = 0;
        rd_addr = '0;
        while (!instr_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (mem_rd) begin
                rd_cnt++;
                rd_addr = mem_addr;
            end
        end
        chk("latency", cnt, 5);
        chk("mem_rd_pulses", rd_cnt, 1);
        chk("mem_addr", rd_addr, v.pc);
        chk("instr", instr, v.exp_instr);
        chk("inc_capt", pc_inc, v.exp_inc);
        if (v.stall != 0) begin
            bad = 1'b0;
            repeat (v.stall) begin
                @(negedge clk);
                if (!instr_valid || instr !== v.exp_instr
                    || pc_ack_out)
                    bad = 1'b1;
            end
            chk("backpressure_hold", bad, 0);
            instr_ready = 1'b1;
            @(negedge clk);
            chk("ack_after_ready", pc_ack_out, 1);
        end
        cnt = 0;
        while (!pc_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("ack_rise", pc_ack_out, 1);
        chk("valid_clr_at_ack", instr_valid, 0);
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (pc_inc !== v.exp_inc || !pc_ack_out)
                bad = 1'b1;
        end
        pc_ack = 1'b0;
        cnt = 0;
        while (pc_ack_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (pc_ack_out && pc_inc !== v.exp_inc)
                bad = 1'b1;
        end
        chk("inc_stable", bad, 0);
        chk("ack_fall_latency", cnt, 3);
        repeat (2) @(negedge clk);
        chk("mem_addr_held", mem_addr, v.pc);
        halt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h10, 8'h3A, 1'b0, 0, 8'h3A, 2'b01};
        vecs[1] = '{8'h20, 8'hC5, 1'b0, 0, 8'hC5, 2'b10};
        vecs[2] = '{8'h30, 8'h01, 1'b1, 0, 8'h01, 2'b00};
        vecs[3] = '{8'h40, 8'h80, 1'b0, 0, 8'h80, 2'b01};
        vecs[4] = '{8'h41, 8'h7F, 1'b0, 7, 8'h7F, 2'b01};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 0, 8'hFF, 2'b10};
        for (int i = 0; i < 256; i++)
            mem[i] = 8'h00;

        rst_n       = 1'b1;
        pc_in       = 8'h00;
        pc_ack      = 1'b0;
        instr_ready = 1'b0;
        halt        = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs",
            {pc_ack_out, pc_inc, mem_rd, mem_addr,
             instr, instr_valid}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_fetch", {mem_rd, instr_valid}, 0);

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i]);

        // reset while pc_ack_out is high
        mem[8'h55] = 8'h9C;
        mem[8'h66] = 8'h42;
        @(negedge clk);
        pc_in       = 8'h55;
        instr_ready = 1'b1;
        pc_ack      = 1'b1;
        n = 0;
        while (!pc_ack_out && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pre_ack", pc_ack_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack_drop", pc_ack_out, 0);
        chk("rst_all_zero",
            {pc_ack_out, pc_inc, mem_rd, mem_addr,
             instr, instr_valid}, 0);
        pc_in = 8'h66;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_refetch_lat", n, 5);
        chk("rst_refetch_instr", instr, 8'h42);
        chk("rst_refetch_addr", mem_addr, 8'h66);
        n = 0;
        while (!pc_ack_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_refetch_ack", pc_ack_out, 1);
        chk("rst_refetch_inc", pc_inc, 2'b01);
        pc_ack = 1'b0;
        n = 0;
        while (pc_ack_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_refetch_rel", pc_ack_out, 0);
        repeat (3) @(negedge clk);

        // asynchronous PC stepping through four addresses
        for (int i = 0; i < 4; i++)
            mem[i] = 8'h11 * (i + 1);
        seq_done = 1'b0;
        seq_tmo  = 1'b0;
        prev_v   = 1'b0;
        seq_pc   = 8'h00;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    pc_in = seq_pc;
                    #3 pc_ack = 1'b1;
                    mt = 0;
                    while (!pc_ack_out && mt < 2000) begin
                        #1;
                        mt++;
                    end
                    if (mt >= 2000)
                        seq_tmo = 1'b1;
                    seq_pc = seq_pc + {6'd0, pc_inc};
                    #7 pc_ack = 1'b0;
                    mt = 0;
                    while (pc_ack_out && mt < 2000) begin
                        #1;
                        mt++;
                    end
                    if (mt >= 2000)
                        seq_tmo = 1'b1;
                    #4;
                end
                repeat (10) @(negedge clk);
                seq_done = 1'b1;
            end
            begin
                while (!seq_done) begin
                    @(negedge clk);
                    if (instr_valid && !prev_v)
                        seen_q.push_back({mem_addr, instr});
                    prev_v = instr_valid;
                end
            end
        join
        chk("seq_timeout", seq_tmo, 0);
        chk("seq_count", seen_q.size(), 4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
            chk("seq_addr", seen_q[i][15:8], i);
            chk("seq_instr", seen_q[i][7:0], 8'h11 * (i + 1));
        end
        chk("seq_final_pc", seq_pc, 8'h04);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
